// File: rtl/bus_dma_pkg.sv
// Shared types and constants for bus initiators on the peripheral memory bus.
// Holds the DMA state encoding, the bus mask encodings and the registered request bundle.
package bus_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_GAP,
      ST_WR,
      ST_WR_GAP,
      ST_ABORT
   } dma_state_t;

   localparam int         WORD_BYTES = 4;
   localparam logic [3:0] MASK_READ  = 4'h0;
   localparam logic [3:0] MASK_WRITE = 4'hF;

   typedef struct packed {
      logic [31:0] address;
      logic        sel;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } bus_req_t;

   localparam bus_req_t BUS_REQ_IDLE = '{address: 32'h0, sel: 1'b0, mask: MASK_READ, wdata: 32'h0};

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/bus_dma_if.sv
// Peripheral memory bus seen from one initiator and one responder.
// Signal names match the responder-side bus already used by the CPU.
interface bus_dma_if;

   logic [31:0] address_out;
   logic        sel_out;
   logic [3:0]  write_mask_out;
   logic [31:0] write_value_out;
   logic [31:0] read_value_in;
   logic        ready_in;

   modport master (
      output address_out, sel_out, write_mask_out, write_value_out,
      input  read_value_in, ready_in
   );

   modport slave (
      input  address_out, sel_out, write_mask_out, write_value_out,
      output read_value_in, ready_in
   );

endinterface

// File: rtl/bus_watchdog.sv
// Counts consecutive stalled cycles of an active bus transaction.
// expired is combinational so the initiator can leave the transaction exactly TIMEOUT cycles after select.
module bus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic ack,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] stall_cnt;

   // An idle bus keeps the count at zero, so every new select starts from a clean count.
   always_ff @(posedge clk) begin
      if (reset || !active || ack)
         stall_cnt <= '0;
      else
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign expired = active && !ack && (stall_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_dma.sv
// Word-copy engine: reads one word from the source range, writes it to the destination range, repeats.
// A bus watchdog aborts the copy when a responder stops answering.
module bus_dma
   import bus_dma_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [15:0] len,
   output logic        busy,
   output logic        done,
   output logic        error,
   bus_dma_if.master   bus
);

   localparam logic [31:0] STEP = 32'(WORD_BYTES);

   dma_state_t  state;
   bus_req_t    req;
   logic [31:0] src;
   logic [31:0] dst;
   logic [31:0] data;
   logic [15:0] count;
   logic        expired;

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .active  (req.sel),
      .ack     (bus.ready_in),
      .expired (expired)
   );

   assign bus.address_out     = req.address;
   assign bus.sel_out         = req.sel;
   assign bus.write_mask_out  = req.mask;
   assign bus.write_value_out = req.wdata;

   // Copy pointers and the data word carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         req   <= BUS_REQ_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         error <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  error <= 1'b0;
                  if (len == 16'd0) begin
                     done <= 1'b1;
                  end else begin
                     src   <= word_align(src_addr);
                     dst   <= word_align(dst_addr);
                     count <= len;
                     busy  <= 1'b1;
                     req   <= '{address: word_align(src_addr), sel: 1'b1, mask: MASK_READ, wdata: req.wdata};
                     state <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (expired) begin
                  req.sel <= 1'b0;
                  state   <= ST_ABORT;
               end else if (bus.ready_in) begin
                  data    <= bus.read_value_in;
                  req.sel <= 1'b0;
                  state   <= ST_RD_GAP;
               end
            end
            ST_RD_GAP: begin
               req   <= '{address: dst, sel: 1'b1, mask: MASK_WRITE, wdata: data};
               state <= ST_WR;
            end
            ST_WR: begin
               if (expired) begin
                  req.sel <= 1'b0;
                  state   <= ST_ABORT;
               end else if (bus.ready_in) begin
                  src     <= src + STEP;
                  dst     <= dst + STEP;
                  count   <= count - 16'd1;
                  req.sel <= 1'b0;
                  if (count == 16'd1) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_WR_GAP;
                  end
               end
            end
            ST_WR_GAP: begin
               req   <= '{address: src, sel: 1'b1, mask: MASK_READ, wdata: req.wdata};
               state <= ST_RD;
            end
            ST_ABORT: begin
               error <= 1'b1;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/bus_dma.md
# bus_dma

Word-copy engine acting as an initiator on the peripheral memory bus: copies a block of 32-bit words from a source address range to a destination address range through ordinary bus reads and writes. It sits beside the CPU in the SoC and drives the same responder-side bus, so LED, timer and RAM peripherals can be loaded or dumped without software loops. The copy is started by a one-cycle `start` pulse and finishes with a one-cycle `done` pulse. A watchdog aborts the copy if a responder never answers.

## Interface
- `TIMEOUT`, default 255: the number of consecutive cycles `sel_out` may stay high without `ready_in` before the copy aborts.
- `clk`  in  1  clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; only sampled in IDLE.
- `src_addr`  in  32  source byte address; bits [1:0] ignored (forced to 0).
- `dst_addr`  in  32  destination byte address; bits [1:0] ignored.
- `len`  in  16  number of words to copy; 0 is legal.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse when a copy ends (normal, zero-length, or abort).
- `error`  out  1  set on timeout abort; held until the next accepted start or reset.
- `address_out`  out  32  bus address, always word-aligned.
- `sel_out`  out  1  bus select; high for the whole transaction.
- `write_mask_out`  out  4  byte enables; 4'hF means write, 4'h0 means read.
- `write_value_out`  out  32  write data.
- `read_value_in`  in  32  read data; valid in the cycle `ready_in` is high.
- `ready_in`  in  1  the responder completes the transaction in any cycle where `sel_out && ready_in`.

## Operation
- **States:** IDLE, RD, RD_GAP, WR, WR_GAP, ABORT.
- **IDLE, start with len≠0:**
  - latch src/dst (aligned) and count=len;
  - clear `error`;
  - go to RD.
- **IDLE, start with len=0:** `done` pulses next cycle, `error` cleared, `busy` stays 0, no bus activity.
- **RD:**
  - `sel_out`=1, `address_out`=src, `write_mask_out`=0.
  - On `ready_in`: latch `read_value_in` into the data register, then go to RD_GAP.
- **RD_GAP:** `sel_out`=0 for exactly one cycle, then go to WR.
- **WR:**
  - `sel_out`=1, `address_out`=dst, `write_mask_out`=4'hF, `write_value_out`=data register.
  - On `ready_in`: src+=4, dst+=4, count-=1.
  - If the old count was 1, go to IDLE with `done`=1 and `busy`=0. Otherwise go to WR_GAP.
- **WR_GAP:** `sel_out`=0 for one cycle, then go to RD.
- **Address arithmetic:** modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 silently.
- **Watchdog:**
  - The counter clears whenever `sel_out` goes high.
  - It increments each cycle that `sel_out` is high with `ready_in` low.
  - When it reaches `TIMEOUT`, go to ABORT.
- **ABORT:** one cycle with `sel_out`=0. Then `error`=1 and `done`=1, `busy`=0, go to IDLE. Remaining words are not copied.
- **start while busy:** ignored, with no effect on the running copy.
- **reset:**
  - At any time, on the next edge: state=IDLE; `sel_out`, `busy`, `done`, `error` and `write_mask_out` = 0; `address_out` and `write_value_out` = 0.
  - A transaction in flight is dropped.
- **Bus output stability:** `address_out`, `write_mask_out` and `write_value_out` are held constant for the whole time `sel_out` is high.

## Timing
- All outputs are registered; none depends combinationally on any input.
- Start accepted on edge 0 → `sel_out` high with the source address in cycle 1.
- With a zero-wait responder (`ready_in`=`sel_out`), each word takes 4 cycles (RD, RD_GAP, WR, WR_GAP). For len=N, `done` is high in cycle 4N.
- Each wait state the responder inserts adds one cycle to the transaction it stalls.
- A zero-length start gives `done` in cycle 1.
- Timeout: `sel_out` high in cycle k and no ready → `sel_out` low at k+`TIMEOUT`, `done`/`error` high at k+`TIMEOUT`+1.
- `busy` is high in cycles 1..4N-1 and low in the cycle `done` is high.

## Structure
- **Package `bus_dma_pkg`:**
  - state enum `dma_state_t`;
  - `WORD_BYTES`=4;
  - `MASK_READ`=4'h0, `MASK_WRITE`=4'hF;
  - a bus request struct (address, sel, mask, wdata) shared with future bus initiators.
- **Sub-module `bus_watchdog`:**
  - parameter `TIMEOUT`;
  - inputs `clk`, `reset`, `active`, `ack`;
  - output `expired`, a one-cycle pulse.
- Everything else lives in a single FSM in `bus_dma`.

## Test plan
- **Single word:** src=0x100, dst=0x200, len=1, zero-wait responder, memory[0x100]=0xDEADBEEF → read at 0x100 in cycle 1, write 0xDEADBEEF to 0x200 with mask F in cycle 3, `done` in cycle 4, `error`=0.
- **Four words with wait states:** the responder inserts 2 wait cycles on every transaction; the destination matches the source for 4 words; `done` in cycle 4·4+8·2=32; `sel_out` is low for exactly one cycle between transactions.
- **Zero length and unaligned input:** len=0 → `done` in cycle 1 with no `sel_out` activity. src=0x103, len=1 → the first read address is 0x100.
- **Timeout:** `TIMEOUT`=8, the responder never asserts ready on the write → `error`=1 and `done` pulse 9 cycles after WR `sel_out` rises, `busy`=0; a following valid start clears `error`.
- **Reset mid-copy and start while busy:** reset asserted in the WR state of word 2 of 4 → `sel_out`=0 next cycle, all outputs at reset values. A start pulse while busy changes nothing.
- **Address wrap:** src=0xFFFF_FFFC, len=2 → the second read address is 0x0000_0000.
